sdram_arbiter: RTL and testbench

//  Owns the single SDRAM command/address/data bus and shares it between init, auto-refresh,

---
 rtl/sdram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAM command/address/data bus between the
// init, auto-refresh, write and read sequencers using an enable/end handshake.
// Refresh always has top priority. Optional macro SDRAM_ARB_RR_EN makes write
// and read alternate when both are pending; undefined gives write > read.
module sdram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQ_W   = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARBIT,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t state;
    state_t state_next;

    assign sdram_cke = 1'b1;

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            state <= ST_INIT;
        else
            state <= state_next;
    end

`ifdef SDRAM_ARB_RR_EN
    logic last_wr;

    // Remember whether write or read was granted last; resets to read so write goes first
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            last_wr <= 1'b0;
        else if (state == ST_ARBIT && state_next == ST_WRITE)
            last_wr <= 1'b1;
        else if (state == ST_ARBIT && state_next == ST_READ)
            last_wr <= 1'b0;
    end
`endif

    // Next-state: priority arbitration in ARBIT, owners hold the bus until their end pulse
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: begin
                if (init_end)
                    state_next = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (aref_req)
                    state_next = ST_AREF;
`ifdef SDRAM_ARB_RR_EN
                else if (wr_req && rd_req)
                    state_next = last_wr ? ST_READ : ST_WRITE;
`endif
                else if (wr_req)
                    state_next = ST_WRITE;
                else if (rd_req)
                    state_next = ST_READ;
            end
            ST_AREF: begin
                if (aref_end)
                    state_next = ST_ARBIT;
            end
            ST_WRITE: begin
                if (wr_end)
                    state_next = ST_ARBIT;
            end
            ST_READ: begin
                if (rd_end)
                    state_next = ST_ARBIT;
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Outputs: grant decode and zero-latency bus mux; reset forces the idle bus at once
    always_comb begin
        aref_en      = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        sdram_cmd    = CMD_NOP;
        sdram_ba     = '0;
        sdram_addr   = '0;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = '0;
        if (!sys_rst) begin
            sdram_dq_out = wr_sdram_data;
            case (state)
                ST_INIT: begin
                    sdram_cmd  = init_cmd;
                    sdram_ba   = init_ba;
                    sdram_addr = init_addr;
                end
                ST_AREF: begin
                    aref_en    = 1'b1;
                    sdram_cmd  = aref_cmd;
                    sdram_ba   = aref_ba;
                    sdram_addr = aref_addr;
                end
                ST_WRITE: begin
                    wr_en       = 1'b1;
                    sdram_cmd   = wr_cmd;
                    sdram_ba    = wr_ba;
                    sdram_addr  = wr_addr;
                    sdram_dq_oe = wr_sdram_en;
                end
                ST_READ: begin
                    rd_en      = 1'b1;
                    sdram_cmd  = rd_cmd;
                    sdram_ba   = rd_ba;
                    sdram_addr = rd_addr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus with per-cycle expected bus snapshots
// queued by the stimulus and checked by an independent negedge monitor.
module tb_sdram_arbiter;

    localparam logic [3:0]  NOP   = 4'b0111;
    localparam logic [3:0]  I_CMD = 4'b0010;
    localparam logic [3:0]  A_CMD = 4'b0001;
    localparam logic [3:0]  W_CMD = 4'b0100;
    localparam logic [3:0]  R_CMD = 4'b0101;
    localparam logic [1:0]  I_BA  = 2'd1;
    localparam logic [1:0]  A_BA  = 2'd0;
    localparam logic [1:0]  W_BA  = 2'd2;
    localparam logic [1:0]  R_BA  = 2'd3;
    localparam logic [12:0] I_AD  = 13'h0101;
    localparam logic [12:0] A_AD  = 13'h0400;
    localparam logic [12:0] W_AD  = 13'h0123;
    localparam logic [12:0] R_AD  = 13'h0456;
    localparam logic [15:0] WDATA = 16'h00A5;

    bit clk = 1'b0;
    logic rst, init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
    logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic [15:0] wr_sdram_data;
    logic aref_en, wr_en, rd_en, sdram_cke, sdram_dq_oe;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;

    typedef struct {
        int          cyc;
        string       name;
        logic [39:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    sdram_arbiter #(.ADDR_W(13), .BA_W(2), .DQ_W(16)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
        .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected bus snapshot for the current cycle
    task automatic expect_bus(input string name, input logic [2:0] en, input logic [3:0] cmd,
                              input logic [1:0] ba, input logic [12:0] addr, input logic oe,
                              input logic [15:0] dq);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.v    = {en, 1'b1, cmd, ba, addr, oe, dq};
        sb.push_back(e);
    endtask

    task automatic x_rst(input string n);  expect_bus(n, 3'b000, NOP, 2'd0, 13'd0, 1'b0, 16'h0000); endtask
    task automatic x_init(input string n); expect_bus(n, 3'b000, I_CMD, I_BA, I_AD, 1'b0, WDATA);    endtask
    task automatic x_nop(input string n);  expect_bus(n, 3'b000, NOP, 2'd0, 13'd0, 1'b0, WDATA);     endtask
    task automatic x_aref(input string n); expect_bus(n, 3'b100, A_CMD, A_BA, A_AD, 1'b0, WDATA);    endtask
    task automatic x_wr(input string n, input logic oe); expect_bus(n, 3'b010, W_CMD, W_BA, W_AD, oe, WDATA); endtask
    task automatic x_rd(input string n);   expect_bus(n, 3'b001, R_CMD, R_BA, R_AD, 1'b0, WDATA);    endtask

    // Monitor: grant exclusivity every cycle, plus queued snapshots when their cycle arrives
    always @(negedge clk) begin
        logic [39:0] act;
        act = {aref_en, wr_en, rd_en, sdram_cke, sdram_cmd, sdram_ba, sdram_addr,
               sdram_dq_oe, sdram_dq_out};
        checks++;
        if ($countones({aref_en, wr_en, rd_en}) > 1) begin
            errors++;
            $display("FAIL grant_onehot cyc=%0d actual=%b required=at most one", cyc,
                     {aref_en, wr_en, rd_en});
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missed snapshot for cyc=%0d", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            checks++;
            if (act !== sb[0].v) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%h required=%h (en,cke,cmd,ba,addr,oe,dq)",
                         sb[0].name, cyc, act, sb[0].v);
            end
            void'(sb.pop_front());
        end
    end

    initial begin
        int owner;
        rst = 1'b1; init_end = 1'b0;
        aref_req = 1'b0; aref_end = 1'b0; wr_req = 1'b0; wr_end = 1'b0;
        rd_req = 1'b0; rd_end = 1'b0;
        wr_sdram_en = 1'b1; wr_sdram_data = WDATA;
        init_cmd = I_CMD; init_ba = I_BA; init_addr = I_AD;
        aref_cmd = A_CMD; aref_ba = A_BA; aref_addr = A_AD;
        wr_cmd = W_CMD;   wr_ba = W_BA;   wr_addr = W_AD;
        rd_cmd = R_CMD;   rd_ba = R_BA;   rd_addr = R_AD;

        tick(); x_rst("reset_a");
        tick(); x_rst("reset_b");
        tick(); rst = 1'b0; x_init("init_hold");
        tick(); init_end = 1'b1; x_init("init_end_cycle");
        tick(); x_nop("arbit_entry");

        // All three requesters at once: refresh first, then write, read waits
        tick(); aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1; x_nop("arbit_all_req");
        tick(); aref_req = 1'b0; x_aref("aref_grant");
        tick(); aref_end = 1'b1; x_aref("aref_end_cycle");
        tick(); aref_end = 1'b0; x_nop("arbit_after_aref");

        // Ten-word write; refresh raised mid-burst must wait
        tick(); wr_req = 1'b0; x_wr("wr_grant", 1'b1);
        tick(); aref_req = 1'b1; wr_sdram_en = 1'b0; x_wr("wr_dq_off", 1'b0);
        tick(); wr_sdram_en = 1'b1; x_wr("wr_dq_on", 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(); x_wr("wr_burst", 1'b1);
        end
        tick(); wr_end = 1'b1; x_wr("wr_last", 1'b1);
        tick(); wr_end = 1'b0; wr_sdram_en = 1'b0; x_nop("arbit_after_wr");
        tick(); aref_req = 1'b0; x_aref("aref_2_after_wr_end");
        tick(); aref_end = 1'b1; x_aref("aref_end2");
        tick(); aref_end = 1'b0; x_nop("arbit_after_aref2");

        // Read: stray wr_end ignored, wr_sdram_en must not drive the pads
        tick(); rd_req = 1'b0; wr_sdram_en = 1'b1; wr_end = 1'b1; x_rd("rd_grant_stray_end");
        tick(); wr_end = 1'b0; wr_sdram_en = 1'b0; rd_end = 1'b1; x_rd("rd_end_cycle");
        tick(); rd_end = 1'b0; x_nop("arbit_after_rd");
        tick(); wr_req = 1'b1; x_nop("arbit_idle");

        // Reset in the middle of a write
        tick(); wr_req = 1'b0; wr_sdram_en = 1'b1; x_wr("wr_grant2", 1'b1);
        tick(); rst = 1'b1; x_rst("reset_mid_write");
        tick(); x_rst("reset_hold");
        tick(); rst = 1'b0; x_init("init_after_reset");
        tick(); x_nop("arbit_after_reset");

        // Write and read both held: alternate with round robin, write-only otherwise
        tick(); wr_req = 1'b1; rd_req = 1'b1; wr_sdram_en = 1'b0; x_nop("arbit_contend");
        for (int g = 0; g < 3; g++) begin
`ifdef SDRAM_ARB_RR_EN
            owner = (g % 2 == 0) ? 0 : 1;
`else
            owner = 0;
`endif
            tick();
            if (owner == 0) x_wr("contend_grant_w", 1'b0); else x_rd("contend_grant_r");
            tick();
            if (owner == 0) begin wr_end = 1'b1; x_wr("contend_end_w", 1'b0); end
            else begin rd_end = 1'b1; x_rd("contend_end_r"); end
            tick(); wr_end = 1'b0; rd_end = 1'b0;
            if (g == 2) begin wr_req = 1'b0; rd_req = 1'b0; end
            x_nop("contend_gap");
        end
        tick(); x_nop("idle_final");
        tick();
        tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
